// File: rtl/vtj1_irqsched_pkg.sv
// Shared register map and helpers for the vtj1 interrupt scheduler.
package vtj1_irqsched_pkg;

  localparam logic [7:0] REG_ENA  = 8'h00;
  localparam logic [7:0] REG_MODE = 8'h08;
  localparam logic [7:0] REG_PEND = 8'h10;
  localparam logic [7:0] REG_ISR  = 8'h18;
  localparam logic [7:0] REG_VEC  = 8'h80;
  localparam logic [7:0] REG_ELIG = 8'h81;
  localparam logic [7:0] REG_ACK  = 8'h80;
  localparam logic [7:0] REG_EOI  = 8'h84;
  localparam logic [7:0] REG_SEOI = 8'h85;
  localparam logic [7:0] REG_ECLR = 8'h89;

  localparam logic [7:0] VEC_NONE = 8'hFF;

  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] s);
    return w[{s, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/vtj1_irqsched_prienc32.sv
// 32-bit priority encoder: index of the lowest set bit, enc[5]=1 when none set.
module vtj1_irqsched_prienc32 (
  input  logic [31:0] vec,
  output logic [5:0]  enc
);

  always_comb begin
    enc = 6'b100000;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) enc = {1'b0, i[4:0]};
    end
  end

endmodule

// File: rtl/vtj1_irqsched.sv
// Nested-priority interrupt scheduler: edge/level lines, in-service tracking,
// ACK/EOI sequencing and a single registered CPU interrupt request.
module vtj1_irqsched
  import vtj1_irqsched_pkg::*;
#(
  parameter int PRIO_NEST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  adr,
  input  logic [7:0]  adr_d1,
  output logic [7:0]  red,
  input  logic [7:0]  wrt,
  input  logic        wen,
  output logic        irqa,
  output logic        irqb,
  input  logic [31:0] lines,
  output logic        cpu_irq
);

  logic [31:0] ena, mode, isr, e;
  logic [31:0] lines_s, lines_p;
  logic [7:0]  last_vec;
  logic [31:0] pend, cand, nest_mask, e_set, e_clr;
  logic [5:0]  elig, isr_low;
  logic [7:0]  rd_data;
  logic        unused_ok;

  assign irqa      = 1'b0;
  assign irqb      = 1'b0;
  assign unused_ok = ^adr_d1;

  assign pend  = (mode & e) | (~mode & lines_s);
  assign cand  = pend & ena & ~isr;
  assign e_set = mode & lines_s & ~lines_p;

  vtj1_irqsched_prienc32 u_isr_enc  (.vec(isr),              .enc(isr_low));
  vtj1_irqsched_prienc32 u_elig_enc (.vec(cand & nest_mask), .enc(elig));

  // Only lines strictly above the highest-priority in-service line may nest.
  always_comb begin
    nest_mask = '1;
    if (PRIO_NEST != 0 && !isr_low[5]) nest_mask = (32'd1 << isr_low[4:0]) - 32'd1;
  end

  always_comb begin
    e_clr = '0;
    if (wen) begin
      if (adr == REG_ACK && !elig[5]) e_clr[elig[4:0]] = 1'b1;
      if (adr == REG_ECLR)            e_clr[wrt[4:0]]  = 1'b1;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (adr[7:2])
      REG_ENA[7:2]:  rd_data = byte_sel(ena,  adr[1:0]);
      REG_MODE[7:2]: rd_data = byte_sel(mode, adr[1:0]);
      REG_PEND[7:2]: rd_data = byte_sel(pend, adr[1:0]);
      REG_ISR[7:2]:  rd_data = byte_sel(isr,  adr[1:0]);
      default:       rd_data = 8'h00;
    endcase
    if (adr == REG_VEC)  rd_data = last_vec;
    if (adr == REG_ELIG) rd_data = elig[5] ? VEC_NONE : {3'd0, elig[4:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ena      <= '0;
      mode     <= '0;
      isr      <= '0;
      e        <= '0;
      lines_s  <= '0;
      lines_p  <= '0;
      last_vec <= VEC_NONE;
      cpu_irq  <= 1'b0;
      red      <= 8'h00;
    end else begin
      lines_s <= lines;
      lines_p <= lines_s;
      cpu_irq <= !elig[5];
      // A fresh edge beats a same-cycle clear so no edge is ever lost.
      e       <= (e & ~e_clr) | e_set;
      red     <= wen ? wrt : rd_data;
      if (wen) begin
        if (adr[7:2] == REG_ENA[7:2])  ena[{adr[1:0], 3'b000} +: 8]  <= wrt;
        if (adr[7:2] == REG_MODE[7:2]) mode[{adr[1:0], 3'b000} +: 8] <= wrt;
        case (adr)
          REG_ACK: begin
            if (!elig[5]) begin
              isr[elig[4:0]] <= 1'b1;
              last_vec       <= {3'd0, elig[4:0]};
            end else begin
              last_vec <= VEC_NONE;
            end
          end
          REG_EOI:  if (!isr_low[5]) isr[isr_low[4:0]] <= 1'b0;
          REG_SEOI: isr[wrt[4:0]] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vtj1_irqsched.sv
// Directed vector bench for vtj1_irqsched, with a PRIO_NEST=0 instance alongside.
module tb_vtj1_irqsched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  adr = 8'h00;
  logic [7:0]  adr_d1 = 8'h00;
  logic [7:0]  wrt = 8'h00;
  logic        wen = 1'b0;
  logic [31:0] lines = '0;
  logic [7:0]  red, red_n0;
  logic        irqa, irqb, irqa_n0, irqb_n0;
  logic        cpu_irq, cpu_irq_n0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) adr_d1 <= adr;

  vtj1_irqsched #(.PRIO_NEST(1)) dut (
    .clk(clk), .rst(rst), .adr(adr), .adr_d1(adr_d1), .red(red), .wrt(wrt),
    .wen(wen), .irqa(irqa), .irqb(irqb), .lines(lines), .cpu_irq(cpu_irq)
  );

  vtj1_irqsched #(.PRIO_NEST(0)) dut_n0 (
    .clk(clk), .rst(rst), .adr(adr), .adr_d1(adr_d1), .red(red_n0), .wrt(wrt),
    .wen(wen), .irqa(irqa_n0), .irqb(irqb_n0), .lines(lines), .cpu_irq(cpu_irq_n0)
  );

  typedef struct {
    logic        rst;
    logic        wen;
    logic [7:0]  adr;
    logic [7:0]  wrt;
    logic [31:0] lines;
    logic [7:0]  exp_red;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic w, input logic [7:0] a,
                              input logic [7:0] d, input logic [31:0] l,
                              input logic [7:0] er, input logic ei);
    vec_t v;
    v.rst = r; v.wen = w; v.adr = a; v.wrt = d; v.lines = l;
    v.exp_red = er; v.exp_irq = ei;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic drive(input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [31:0] l);
    @(negedge clk);
    rst = r; wen = w; adr = a; wrt = d; lines = l;
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] LE = 32'h0010_0000;

  initial begin
    // reset, idle reads
    add(1, 0, 8'h00, 8'h00, 32'h00, 8'h00, 0);
    add(0, 0, 8'h80, 8'h00, 32'h00, 8'hFF, 0);
    add(0, 0, 8'h81, 8'h00, 32'h00, 8'hFF, 0);
    add(0, 0, 8'h18, 8'h00, 32'h00, 8'h00, 0);
    // level lines 2 and 5, ack line 2
    add(0, 1, 8'h00, 8'h24, 32'h00, 8'h24, 0);
    add(0, 0, 8'h00, 8'h00, 32'h00, 8'h24, 0);
    add(0, 0, 8'h81, 8'h00, 32'h24, 8'hFF, 0);
    add(0, 0, 8'h81, 8'h00, 32'h24, 8'h02, 1);
    add(0, 1, 8'h80, 8'h00, 32'h24, 8'h00, 1);
    add(0, 0, 8'h80, 8'h00, 32'h24, 8'h02, 0);
    add(0, 0, 8'h18, 8'h00, 32'h24, 8'h04, 0);
    add(0, 0, 8'h81, 8'h00, 32'h24, 8'hFF, 0);
    // nest line 1 over line 2, then two nonspecific EOIs
    add(0, 1, 8'h00, 8'h26, 32'h24, 8'h26, 0);
    add(0, 0, 8'h81, 8'h00, 32'h26, 8'hFF, 0);
    add(0, 0, 8'h81, 8'h00, 32'h26, 8'h01, 1);
    add(0, 1, 8'h80, 8'h00, 32'h26, 8'h00, 1);
    add(0, 0, 8'h80, 8'h00, 32'h26, 8'h01, 0);
    add(0, 0, 8'h18, 8'h00, 32'h26, 8'h06, 0);
    add(0, 1, 8'h84, 8'h00, 32'h20, 8'h00, 0);
    add(0, 0, 8'h18, 8'h00, 32'h20, 8'h04, 0);
    add(0, 1, 8'h84, 8'h00, 32'h20, 8'h00, 0);
    add(0, 0, 8'h81, 8'h00, 32'h20, 8'h05, 1);
    add(0, 0, 8'h18, 8'h00, 32'h20, 8'h00, 1);
    // edge mode on line 20: single pulse latches
    add(0, 1, 8'h02, 8'h10, 32'h00, 8'h10, 1);
    add(0, 1, 8'h0A, 8'h10, 32'h00, 8'h10, 0);
    add(0, 0, 8'h12, 8'h00, LE,     8'h00, 0);
    add(0, 0, 8'h81, 8'h00, 32'h00, 8'hFF, 0);
    add(0, 0, 8'h12, 8'h00, 32'h00, 8'h10, 1);
    add(0, 0, 8'h81, 8'h00, 32'h00, 8'h14, 1);
    add(0, 1, 8'h80, 8'h00, 32'h00, 8'h00, 1);
    add(0, 0, 8'h80, 8'h00, 32'h00, 8'h14, 0);
    add(0, 0, 8'h12, 8'h00, 32'h00, 8'h00, 0);
    add(0, 1, 8'h85, 8'h14, 32'h00, 8'h14, 0);
    add(0, 0, 8'h1A, 8'h00, 32'h00, 8'h00, 0);
    // edge coinciding with latch clear: set wins; a lone clear then clears
    add(0, 0, 8'h81, 8'h00, LE,     8'hFF, 0);
    add(0, 1, 8'h89, 8'h14, 32'h00, 8'h14, 0);
    add(0, 0, 8'h12, 8'h00, 32'h00, 8'h10, 1);
    add(0, 1, 8'h89, 8'h14, 32'h00, 8'h14, 1);
    add(0, 0, 8'h12, 8'h00, 32'h00, 8'h00, 0);
    // spurious ACK, EOI with nothing in service
    add(0, 1, 8'h80, 8'h00, 32'h00, 8'h00, 0);
    add(0, 0, 8'h80, 8'h00, 32'h00, 8'hFF, 0);
    add(0, 0, 8'h18, 8'h00, 32'h00, 8'h00, 0);
    add(0, 1, 8'h84, 8'h00, 32'h00, 8'h00, 0);
    add(0, 0, 8'h18, 8'h00, 32'h00, 8'h00, 0);
    // reset mid-handler
    add(0, 0, 8'h81, 8'h00, 32'h20, 8'hFF, 0);
    add(0, 0, 8'h81, 8'h00, 32'h20, 8'h05, 1);
    add(0, 1, 8'h80, 8'h00, 32'h20, 8'h00, 1);
    add(0, 0, 8'h18, 8'h00, 32'h20, 8'h20, 0);
    add(1, 0, 8'h00, 8'h00, 32'h00, 8'h00, 0);
    add(0, 0, 8'h80, 8'h00, 32'h00, 8'hFF, 0);
    add(0, 0, 8'h18, 8'h00, 32'h00, 8'h00, 0);
    add(0, 0, 8'h00, 8'h00, 32'h00, 8'h00, 0);
    add(0, 0, 8'h0A, 8'h00, 32'h00, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].wen, vecs[i].adr, vecs[i].wrt, vecs[i].lines);
      check("red", i, 32'(red), 32'(vecs[i].exp_red));
      check("cpu_irq", i, 32'(cpu_irq), 32'(vecs[i].exp_irq));
    end
    check("irqa_irqb", 100, {30'd0, irqa, irqb}, 32'd0);

    // Both instances were just reset together; compare nesting vs no nesting.
    drive(0, 1, 8'h00, 8'h24, 32'h00);
    drive(0, 0, 8'h81, 8'h00, 32'h24);
    drive(0, 0, 8'h81, 8'h00, 32'h24);
    check("nest1_elig", 200, 32'(red), 32'h02);
    check("nest0_elig", 200, 32'(red_n0), 32'h02);
    drive(0, 1, 8'h80, 8'h00, 32'h24);
    drive(0, 0, 8'h81, 8'h00, 32'h24);
    check("nest1_elig", 201, 32'(red), 32'hFF);
    check("nest0_elig", 201, 32'(red_n0), 32'h05);
    check("nest1_irq", 201, 32'(cpu_irq), 32'd0);
    check("nest0_irq", 201, 32'(cpu_irq_n0), 32'd1);
    drive(0, 1, 8'h80, 8'h00, 32'h24);
    drive(0, 0, 8'h18, 8'h00, 32'h24);
    check("nest1_isr", 202, 32'(red), 32'h04);
    check("nest0_isr", 202, 32'(red_n0), 32'h24);
    drive(0, 0, 8'h80, 8'h00, 32'h24);
    check("nest1_vec", 203, 32'(red), 32'hFF);
    check("nest0_vec", 203, 32'(red_n0), 32'h05);
    check("n0_irqa_irqb", 204, {30'd0, irqa_n0, irqb_n0}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
